// File: rtl/rx_pkg.sv
// Shared definitions for the RX compare-buffer sequencer.
// Holds the default frame limit, buffer address width, result counter width
// and the controller state encoding.
package rx_pkg;

    localparam int MAX_LEN = 1500;
    localparam int AW      = 12;
    localparam int CNT_W   = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STORE   = 3'd1,
        HOLD    = 3'd2,
        COMPARE = 3'd3,
        FLUSH   = 3'd4
    } state_t;

endpackage

// File: rtl/rx_frame_compare_ctrl.sv
// Stores the first frame of a redundant pair in the compare buffer, then streams
// the second frame against it. Reports match, byte-mismatch count and length agreement.
// No backpressure: one byte per rx_valid. Result is 2 cycles after the last byte (1 cycle on overflow).
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   clear               synchronous abort, discards the stored frame
//   rx_valid/data/last  incoming MAC byte stream
//   ram_addra/dina/wea  buffer port A (store path, write on the sampling edge)
//   ram_addrb/doutb     buffer port B (compare path, 1-cycle registered read)
//   ram_web             tied low, port B never writes
//   busy                controller not idle
//   cmp_*               result group, updated together on the cmp_done pulse
module rx_frame_compare_ctrl
    import rx_pkg::*;
#(
    parameter int MAX_LEN = rx_pkg::MAX_LEN,
    parameter int AW      = rx_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 rx_last,
    output logic [AW-1:0]        ram_addra,
    output logic [7:0]           ram_dina,
    output logic                 ram_wea,
    output logic [AW-1:0]        ram_addrb,
    input  logic [7:0]           ram_doutb,
    output logic                 ram_web,
    output logic                 busy,
    output logic                 cmp_done,
    output logic                 cmp_match,
    output logic                 cmp_len_err,
    output logic                 cmp_ovf,
    output logic [CNT_W-1:0]     cmp_mismatch_cnt
);

    localparam logic [AW-1:0] LP_MAX   = AW'(MAX_LEN);
    localparam logic [AW:0]   LP_MAX_W = (AW+1)'(MAX_LEN);
    localparam logic [AW-1:0] LP_ONE   = AW'(1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_stored_len;
    logic [AW-1:0]      r_rx_len;
    logic               r_ovf;
    logic               r_pend;
    logic               r_inrange;
    logic [7:0]         r_byte;
    logic [CNT_W-1:0]   r_mm_cnt;

    logic               r_cmp_done;
    logic               r_cmp_match;
    logic               r_cmp_len_err;
    logic               r_cmp_ovf;
    logic [CNT_W-1:0]   r_cmp_mm;

    logic               w_acc;
    logic               w_wr_room;
    logic               w_ovf_nxt;
    logic [AW:0]        w_wr_sum;
    logic [AW-1:0]      w_wr_len;
    logic [AW-1:0]      w_wr_ptr_inc;
    logic [AW-1:0]      w_rd_ptr_inc;
    logic               w_mm_hit;
    logic [CNT_W-1:0]   w_mm_cnt_nxt;
    logic               w_wea;
    logic [AW-1:0]      w_addra;
    logic [AW-1:0]      w_addrb;

    // clear (and reset) win over a byte arriving in the same cycle
    assign w_acc        = rx_valid & ~clear & ~rst;
    assign w_wr_room    = (r_wr_ptr < LP_MAX);
    assign w_ovf_nxt    = r_ovf | (w_acc & ~w_wr_room);
    assign w_wr_sum     = {1'b0, r_wr_ptr} + {1'b0, LP_ONE};
    assign w_wr_len     = (w_wr_sum > LP_MAX_W) ? LP_MAX : w_wr_sum[AW-1:0];
    // both pointers stick at all-ones rather than wrapping on absurdly long frames
    assign w_wr_ptr_inc = (&r_wr_ptr) ? r_wr_ptr : r_wr_ptr + LP_ONE;
    assign w_rd_ptr_inc = (&r_rd_ptr) ? r_rd_ptr : r_rd_ptr + LP_ONE;

    // second pipeline stage: byte registered last cycle vs. buffer read data now
    assign w_mm_hit     = r_pend & r_inrange & (r_byte != ram_doutb);
    assign w_mm_cnt_nxt = r_mm_cnt + CNT_W'(w_mm_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wea       = 1'b0;
        w_addra     = '0;
        w_addrb     = '0;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_wea       = 1'b1;
                    w_state_nxt = rx_last ? HOLD : STORE;
                end
            end
            STORE: begin
                w_addra = r_wr_ptr;
                if (w_acc) begin
                    w_wea = w_wr_room;
                    if (rx_last) begin
                        w_state_nxt = w_ovf_nxt ? IDLE : HOLD;
                    end
                end
            end
            HOLD: begin
                // the byte accepted here is index 0 of the second frame
                if (w_acc) begin
                    w_state_nxt = rx_last ? FLUSH : COMPARE;
                end
            end
            COMPARE: begin
                w_addrb = r_rd_ptr;
                if (w_acc && rx_last) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (clear) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_stored_len <= '0;
            r_rx_len     <= '0;
            r_ovf        <= 1'b0;
            r_pend       <= 1'b0;
            r_inrange    <= 1'b0;
            r_byte       <= '0;
            r_mm_cnt     <= '0;
            r_cmp_done   <= 1'b0;
        end else begin
            r_cmp_done <= 1'b0;
            r_pend     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_wr_ptr <= LP_ONE;
                        r_rd_ptr <= '0;
                        r_ovf    <= 1'b0;
                        r_mm_cnt <= '0;
                        if (rx_last) begin
                            r_stored_len <= LP_ONE;
                        end
                    end
                end
                STORE: begin
                    if (w_acc) begin
                        r_wr_ptr <= w_wr_ptr_inc;
                        r_ovf    <= w_ovf_nxt;
                        if (rx_last) begin
                            r_stored_len <= w_wr_len;
                            if (w_ovf_nxt) begin
                                r_cmp_done <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_acc) begin
                        r_pend    <= 1'b1;
                        r_byte    <= rx_data;
                        r_inrange <= 1'b1;
                        r_rd_ptr  <= LP_ONE;
                        if (rx_last) begin
                            r_rx_len <= LP_ONE;
                        end
                    end
                end
                COMPARE: begin
                    r_mm_cnt <= w_mm_cnt_nxt;
                    if (w_acc) begin
                        r_pend    <= 1'b1;
                        r_byte    <= rx_data;
                        r_inrange <= (r_rd_ptr < r_stored_len);
                        r_rd_ptr  <= w_rd_ptr_inc;
                        if (rx_last) begin
                            r_rx_len <= w_rd_ptr_inc;
                        end
                    end
                end
                FLUSH: begin
                    r_mm_cnt   <= w_mm_cnt_nxt;
                    r_cmp_done <= 1'b1;
                end
                default: begin
                    r_pend <= 1'b0;
                end
            endcase
        end
    end

    // Result group: only rewritten alongside a done pulse, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_match   <= 1'b0;
            r_cmp_len_err <= 1'b0;
            r_cmp_ovf     <= 1'b0;
            r_cmp_mm      <= '0;
        end else if (!clear) begin
            if (r_state == STORE && w_acc && rx_last && w_ovf_nxt) begin
                r_cmp_match   <= 1'b0;
                r_cmp_len_err <= 1'b0;
                r_cmp_ovf     <= 1'b1;
                r_cmp_mm      <= '0;
            end else if (r_state == FLUSH) begin
                r_cmp_match   <= (r_rx_len == r_stored_len) && (w_mm_cnt_nxt == '0);
                r_cmp_len_err <= (r_rx_len != r_stored_len);
                r_cmp_ovf     <= 1'b0;
                r_cmp_mm      <= w_mm_cnt_nxt;
            end
        end
    end

    assign ram_addra        = w_addra;
    assign ram_dina         = w_wea ? rx_data : 8'h00;
    assign ram_wea          = w_wea;
    assign ram_addrb        = w_addrb;
    assign ram_web          = 1'b0;
    assign busy             = (r_state != IDLE);
    assign cmp_done         = r_cmp_done;
    assign cmp_match        = r_cmp_match;
    assign cmp_len_err      = r_cmp_len_err;
    assign cmp_ovf          = r_cmp_ovf;
    assign cmp_mismatch_cnt = r_cmp_mm;

endmodule
